note_lane_draw_ctrl: RTL

Sequences the drawing of the note lane on the VGA adapter. On each beat tick it snapshots the lowest note bits from the note shifter. It then walks every slot and every pixel of each slot's square, emitting one pixel per cycle (x, y, colour, plot) straight into the VGA adapter. Red is drawn for a note, black for a rest. It replaces per-slot ad-hoc timing with a single start/busy/done-handshaked scheduler.

---
 rtl/note_lane_draw_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/note_lane_draw_ctrl.sv
// Note-lane draw scheduler: snapshots note bits on a beat tick, then emits one VGA pixel per cycle.
// Optional macro DRAW_PENDING_START_EN queues one start that arrives while busy.
`timescale 1ns/1ps

module note_lane_draw_ctrl #(
    parameter int unsigned NUM_SLOTS   = 10,
    parameter int unsigned SQUARE_SIZE = 4,
    parameter int unsigned SLOT_PITCH  = 5,
    parameter int unsigned BASE_X      = 0,
    parameter int unsigned BASE_Y      = 60,
    parameter logic [2:0]  NOTE_COLOUR = 3'b100,
    parameter logic [2:0]  REST_COLOUR = 3'b000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] notes,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned PIX_W  = (SQUARE_SIZE > 1) ? $clog2(SQUARE_SIZE) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(SQUARE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SLOTS-1:0] snapshot_q, snapshot_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [PIX_W-1:0]     row_q, row_d;
    logic [PIX_W-1:0]     col_q, col_d;
    logic                 busy_d, done_d, plot_d;
    logic [7:0]           x_d;
    logic [6:0]           y_d;
    logic [2:0]           colour_d;
`ifdef DRAW_PENDING_START_EN
    logic                 pending_q, pending_d;
`endif

    // Next-state, counter walk and next output values
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        slot_d     = slot_q;
        row_d      = row_q;
        col_d      = col_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        plot_d     = 1'b0;
        x_d        = x;
        y_d        = y;
        colour_d   = colour;
`ifdef DRAW_PENDING_START_EN
        pending_d  = pending_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    snapshot_d = notes;
                    slot_d     = '0;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = DRAW;
                end
            end
            DRAW: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                x_d      = 8'(BASE_X + SLOT_PITCH * 32'(slot_q) + 32'(col_q));
                y_d      = 7'(BASE_Y + 32'(row_q));
                colour_d = snapshot_q[slot_q] ? NOTE_COLOUR : REST_COLOUR;
                if (col_q == LAST_PIX) begin
                    col_d = '0;
                    if (row_q == LAST_PIX) begin
                        row_d = '0;
                        if (slot_q == LAST_SLOT) begin
                            state_d = DONE;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else begin
                        row_d = row_q + PIX_W'(1);
                    end
                end else begin
                    col_d = col_q + PIX_W'(1);
                end
`ifdef DRAW_PENDING_START_EN
                if (start) pending_d = 1'b1;
`endif
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef DRAW_PENDING_START_EN
                // A queued (or coincident) start chains straight into the next run
                if (pending_q || start) begin
                    snapshot_d = notes;
                    slot_d     = '0;
                    row_d      = '0;
                    col_d      = '0;
                    pending_d  = 1'b0;
                    state_d    = DRAW;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            slot_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
`ifdef DRAW_PENDING_START_EN
            pending_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            slot_q     <= slot_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy       <= busy_d;
            done       <= done_d;
            plot       <= plot_d;
            x          <= x_d;
            y          <= y_d;
            colour     <= colour_d;
`ifdef DRAW_PENDING_START_EN
            pending_q  <= pending_d;
`endif
        end
    end

endmodule
